cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, tag width to the set.
REQ-002 SHALL have parameter IDX_W, default 3, set-index width.
REQ-003 SHALL have parameter DATA_W, default 16, word width.
REQ-004 SHALL provide port clk, input, 1, the single clock; one clock, all state on its rising edge.
REQ-005 SHALL provide port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL provide CPU ports:
- cpu_req, input, 1, request strobe.
- cpu_wr, input, 1, 1 = write.
- cpu_addr, input, TAG_W+IDX_W+2, {tag,index,word}.
- cpu_wdata, input, DATA_W, write data.
- cpu_rdata, output, DATA_W, read data.
- cpu_ready, output, 1, completion pulse.
REQ-007 SHALL provide set-side outputs: set_index (IDX_W), set_enable (1), set_cmp (1), set_write (1), set_word (2), set_tag (TAG_W), set_data (DATA_W), set_valid_in (1).
REQ-008 SHALL provide set-side inputs: set_hit, set_dirty, set_valid, set_ack (1 each), set_tag_out (TAG_W), set_data_out (DATA_W).
REQ-009 SHALL provide memory ports: mem_req out 1, mem_wr out 1, mem_addr out TAG_W+IDX_W+2, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ack in 1.

Function
REQ-010 SHALL implement states IDLE, COMPARE, WRITEBACK, ALLOCATE, DONE.
REQ-011 SHALL, in IDLE, on cpu_req=1 latch cpu_wr/cpu_addr/cpu_wdata and go to COMPARE next edge.
REQ-012 SHALL ignore cpu_req outside IDLE.
REQ-013 SHALL, in COMPARE, drive set_enable=1, set_cmp=1, set_write=latched wr, set_tag/set_word/set_data from latch, set_index from latch.
REQ-014 SHALL, in COMPARE, hold set-side outputs stable until set_ack=1.
REQ-015 SHALL, on set_ack in COMPARE with set_hit=1 and set_valid=1, capture set_data_out into cpu_rdata (read only) and go to DONE.
REQ-016 SHALL, on a miss with set_valid=1 and set_dirty=1, latch set_tag_out as victim tag and go to WRITEBACK; otherwise go to ALLOCATE.
REQ-017 SHALL run WRITEBACK with a 2-bit word counter from 0 to 3; per word:
- read set (set_enable=1, set_cmp=0, set_write=0, set_word=counter) until set_ack;
- then mem_req=1, mem_wr=1, mem_addr={victim,index,counter}, mem_wdata=captured data until mem_ack.
REQ-018 SHALL leave WRITEBACK for ALLOCATE after word 3 is acknowledged, counter wrapping 3->0.
REQ-019 SHALL run ALLOCATE per word 0..3:
- mem_req=1, mem_wr=0, mem_addr={tag,index,counter} until mem_ack, capturing mem_rdata;
- then set write with set_cmp=0, set_write=1, set_valid_in=1 until set_ack.
REQ-020 SHALL return from ALLOCATE to COMPARE after word 3, replaying the original request, which then hits.
REQ-021 SHALL drop set_enable for at least one cycle between consecutive set operations, and mem_req for at least one cycle between memory transfers.
REQ-022 SHALL, in DONE, assert cpu_ready=1 for exactly one cycle and return to IDLE.
REQ-023 SHALL hold cpu_rdata until the next read completes.
REQ-024 SHALL ignore set_ack and mem_ack when the corresponding request is not asserted.
REQ-025 SHALL complete a hit with 1-cycle set_ack such that cpu_ready is high on the 3rd edge after cpu_req sampling.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-transfer, force IDLE and clear the word counter and latches.
REQ-027 SHALL, on rst=1, drive all outputs to 0, cpu_rdata included.
REQ-028 SHALL issue no set or memory request in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with CACHE_CTRL_STATS_EN defined, add outputs hit_count and miss_count, 16 bits each, 0 on reset.
REQ-030 SHALL increment hit_count on a first-pass COMPARE hit and miss_count on a COMPARE miss, each saturating at 16'hFFFF; the replayed compare after ALLOCATE is not counted.
REQ-031 SHALL, without CACHE_CTRL_STATS_EN, omit the stats ports and logic.

Verification
REQ-032 Cold read miss, addr tag=5'b11101 idx=0 word=3, memory returns 16'h0F0F at word 3 -> four mem reads, four set writes, cpu_rdata=16'h0F0F, cpu_ready one cycle.
REQ-033 Read hit, set_hit=1, set_valid=1, set_data_out=16'h1234, 1-cycle set_ack -> cpu_rdata=16'h1234, cpu_ready on 3rd edge, no mem_req.
REQ-034 Write hit, cpu_wdata=16'hABCD -> set_write=1, set_cmp=1, set_data=16'hABCD, no memory traffic.
REQ-035 Dirty miss, victim tag 5'b00011 -> four mem writes at addrs {00011,idx,0..3}, then four reads at the new tag.
REQ-036 rst pulse during WRITEBACK word 2 -> all outputs 0 immediately; IDLE; new cpu_req serviced normally.
REQ-037 With CACHE_CTRL_STATS_EN defined, run 3 hits + 1 miss -> hit_count=3, miss_count=1.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back cache controller sequencing one external set array and word-wide memory.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss counters (hit_count, miss_count).
module cache_ctrl #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_wr,
  input  logic [TAG_W+IDX_W+1:0] cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  output logic [IDX_W-1:0]       set_index,
  output logic                   set_enable,
  output logic                   set_cmp,
  output logic                   set_write,
  output logic [1:0]             set_word,
  output logic [TAG_W-1:0]       set_tag,
  output logic [DATA_W-1:0]      set_data,
  output logic                   set_valid_in,
  input  logic                   set_hit,
  input  logic                   set_dirty,
  input  logic                   set_valid,
  input  logic                   set_ack,
  input  logic [TAG_W-1:0]       set_tag_out,
  input  logic [DATA_W-1:0]      set_data_out,
  output logic                   mem_req,
  output logic                   mem_wr,
  output logic [TAG_W+IDX_W+1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam int unsigned AddrW = TAG_W + IDX_W + 2;

  typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StAllocate, StDone} state_e;

  state_e              state_q, state_d;
  logic                gap_q, gap_d;
  logic                mem_ph_q, mem_ph_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TAG_W-1:0]    victim_q, victim_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;

  assign req_tag   = addr_q[AddrW-1 -: TAG_W];
  assign req_idx   = addr_q[IDX_W+1 -: IDX_W];
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gap_q    <= 1'b0;
      mem_ph_q <= 1'b0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      mem_ph_q <= mem_ph_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
    end
  end

  // gap_q inserts one idle cycle after every handshake so enable/req always drop between ops.
  always_comb begin
    state_d      = state_q;
    gap_d        = 1'b0;
    mem_ph_d     = mem_ph_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    buf_d        = buf_q;
    rdata_d      = rdata_q;
    cpu_ready    = 1'b0;
    set_index    = '0;
    set_enable   = 1'b0;
    set_cmp      = 1'b0;
    set_write    = 1'b0;
    set_word     = '0;
    set_tag      = '0;
    set_data     = '0;
    set_valid_in = 1'b0;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          wr_d    = cpu_wr;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (!gap_q) begin
          set_enable   = 1'b1;
          set_cmp      = 1'b1;
          set_write    = wr_q;
          set_valid_in = wr_q;  // a write hit keeps the line valid
          set_index    = req_idx;
          set_tag      = req_tag;
          set_word     = addr_q[1:0];
          set_data     = wdata_q;
          if (set_ack) begin
            gap_d = 1'b1;
            cnt_d = '0;
            if (set_hit && set_valid) begin
              if (!wr_q) rdata_d = set_data_out;
              state_d = StDone;
            end else if (set_valid && set_dirty) begin
              victim_d = set_tag_out;
              mem_ph_d = 1'b0;
              state_d  = StWriteback;
            end else begin
              mem_ph_d = 1'b1;
              state_d  = StAllocate;
            end
          end
        end
      end
      StWriteback: begin
        if (!gap_q) begin
          if (!mem_ph_q) begin
            set_enable = 1'b1;
            set_index  = req_idx;
            set_word   = cnt_q;
            if (set_ack) begin
              buf_d    = set_data_out;
              mem_ph_d = 1'b1;
              gap_d    = 1'b1;
            end
          end else begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {victim_q, req_idx, cnt_q};
            mem_wdata = buf_q;
            if (mem_ack) begin
              gap_d    = 1'b1;
              cnt_d    = cnt_q + 2'd1;
              mem_ph_d = 1'b0;
              if (cnt_q == 2'd3) begin
                mem_ph_d = 1'b1;
                state_d  = StAllocate;
              end
            end
          end
        end
      end
      StAllocate: begin
        if (!gap_q) begin
          if (mem_ph_q) begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_idx, cnt_q};
            if (mem_ack) begin
              buf_d    = mem_rdata;
              mem_ph_d = 1'b0;
              gap_d    = 1'b1;
            end
          end else begin
            set_enable   = 1'b1;
            set_write    = 1'b1;
            set_valid_in = 1'b1;
            set_index    = req_idx;
            set_tag      = req_tag;
            set_word     = cnt_q;
            set_data     = buf_q;
            if (set_ack) begin
              gap_d    = 1'b1;
              cnt_d    = cnt_q + 2'd1;
              mem_ph_d = 1'b1;
              if (cnt_q == 2'd3) state_d = StCompare;
            end
          end
        end
      end
      StDone: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic        replay_q;
  logic        cmp_done;
  logic [15:0] hit_q, miss_q;

  assign cmp_done   = (state_q == StCompare) && !gap_q && set_ack;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // replay_q marks the compare re-issued after a fill so it is not counted as a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      if (state_q == StIdle) begin
        replay_q <= 1'b0;
      end else if (state_q == StAllocate && state_d == StCompare) begin
        replay_q <= 1'b1;
      end
      if (cmp_done && set_hit && set_valid && !replay_q && hit_q != 16'hFFFF) begin
        hit_q <= hit_q + 16'd1;
      end
      if (cmp_done && !(set_hit && set_valid) && miss_q != 16'hFFFF) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end
`endif

endmodule
